// File: rtl/cell_pkg.sv
// Shared types and constants for the cell sweep/signature engine.
package cell_pkg;

    localparam int          PAGE_W   = 5;
    localparam int          STIM_W   = 6;
    localparam logic [15:0] SIG_POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT
    } state_t;

    // One MISR step: CCITT-style shift with the cell response folded into the low byte.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
        misr_step = {s[14:0], 1'b0} ^ (s[15] ? SIG_POLY : 16'h0000) ^ {8'h00, d};
    endfunction

endpackage

// File: rtl/cell_misr.sv
// 16-bit multiple-input signature register compacting the 8-bit cell responses.
module cell_misr
    import cell_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        shift_en,
    input  logic [7:0]  data,
    output logic [15:0] sig_next
);

    logic [15:0] r_sig;

    assign sig_next = misr_step(r_sig, data);

    // Reset value is 0, not the seed; the seed is only loaded when a page begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= 16'h0000;
        end else if (seed_load) begin
            r_sig <= seed;
        end else if (shift_en) begin
            r_sig <= sig_next;
        end
    end

endmodule

// File: rtl/cell_sweep_sig.sv
// Sweep engine: walks every 6-bit stimulus over a page range on cell_mux and
// reports one MISR signature per page.
module cell_sweep_sig
    import cell_pkg::*;
#(
    parameter int          SETTLE = 3,
    parameter logic [15:0] SEED   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PAGE_W-1:0] page_first,
    input  logic [PAGE_W-1:0] page_last,
    input  logic              tri_en,
    input  logic [7:0]        cell_out,
    output logic [PAGE_W-1:0] page,
    output logic [STIM_W-1:0] stim,
    output logic              tristate_gate,
    output logic              busy,
    output logic [15:0]       sig,
    output logic [PAGE_W-1:0] sig_page,
    output logic              sig_valid,
    output logic              done
);

    localparam logic [3:0]        CNT_RELOAD = 4'(SETTLE - 1);
    localparam logic [STIM_W-1:0] STIM_LAST  = '1;

    state_t r_state;
    state_t w_state_nx;

    logic [PAGE_W-1:0] r_page;
    logic [PAGE_W-1:0] r_page_last;
    logic [STIM_W-1:0] r_stim;
    logic [3:0]        r_cnt;
    logic              r_tri;
    logic              r_busy;
    logic [15:0]       r_sig;
    logic [PAGE_W-1:0] r_sig_page;
    logic              r_sig_valid;
    logic              r_done;

    logic              w_start_acc;
    logic              w_cnt_dec;
    logic              w_sample;
    logic              w_stim_inc;
    logic              w_to_report;
    logic              w_page_next;
    logic              w_finish;
    logic              w_abort_go;
    logic              w_last_page;
    logic [15:0]       w_misr_next;

    assign w_last_page = (r_page == r_page_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Abort outranks every other transition, but only once a sweep is running.
    always_comb begin
        w_state_nx  = r_state;
        w_start_acc = 1'b0;
        w_cnt_dec   = 1'b0;
        w_sample    = 1'b0;
        w_stim_inc  = 1'b0;
        w_to_report = 1'b0;
        w_page_next = 1'b0;
        w_finish    = 1'b0;
        w_abort_go  = 1'b0;
        if (r_state != ST_IDLE && abort) begin
            w_state_nx = ST_IDLE;
            w_abort_go = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nx  = ST_SETTLE;
                        w_start_acc = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nx = ST_SAMPLE;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    w_sample = 1'b1;
                    if (r_stim == STIM_LAST) begin
                        w_state_nx  = ST_REPORT;
                        w_to_report = 1'b1;
                    end else begin
                        w_state_nx = ST_SETTLE;
                        w_stim_inc = 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (w_last_page) begin
                        w_state_nx = ST_IDLE;
                        w_finish   = 1'b1;
                    end else begin
                        w_state_nx  = ST_SETTLE;
                        w_page_next = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    cell_misr u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (w_start_acc | w_page_next),
        .seed      (SEED),
        .shift_en  (w_sample),
        .data      (cell_out),
        .sig_next  (w_misr_next)
    );

    // page/stim/tristate_gate only move on entry to SETTLE, keeping each stimulus
    // stable for the whole settle window before it is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_page      <= '0;
            r_page_last <= '0;
            r_stim      <= '0;
            r_cnt       <= 4'd0;
            r_tri       <= 1'b0;
            r_busy      <= 1'b0;
            r_sig       <= 16'h0000;
            r_sig_page  <= '0;
            r_sig_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_sig_valid <= w_to_report;
            r_done      <= w_to_report && w_last_page;
            if (w_to_report) begin
                r_sig      <= w_misr_next;
                r_sig_page <= r_page;
            end
            if (w_start_acc) begin
                r_page      <= page_first;
                r_page_last <= page_last;
                r_tri       <= tri_en;
                r_stim      <= '0;
                r_cnt       <= CNT_RELOAD;
                r_busy      <= 1'b1;
            end
            if (w_cnt_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_stim_inc) begin
                r_stim <= r_stim + 6'd1;
                r_cnt  <= CNT_RELOAD;
            end
            if (w_page_next) begin
                r_page <= r_page + 5'd1;
                r_stim <= '0;
                r_cnt  <= CNT_RELOAD;
            end
            if (w_finish || w_abort_go) begin
                r_busy <= 1'b0;
                r_tri  <= 1'b0;
            end
        end
    end

    assign page          = r_page;
    assign stim          = r_stim;
    assign tristate_gate = r_tri;
    assign busy          = r_busy;
    assign sig           = r_sig;
    assign sig_page      = r_sig_page;
    assign sig_valid     = r_sig_valid;
    assign done          = r_done;

endmodule

// File: tb/tb_cell_sweep_sig.sv
// Bench for cell_sweep_sig: random cell_mux lookup table, per-page signature
// scoreboard, stimulus-stability monitor and hand-written corner sequences.
module tb_cell_sweep_sig;

    localparam int SETTLE  = 3;
    localparam int SETTLE0 = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tri_en = 1'b0;
    logic [4:0]  page_first = 5'd0;
    logic [4:0]  page_last = 5'd0;
    logic [7:0]  cell_out;

    logic [4:0]  page, sig_page;
    logic [5:0]  stim;
    logic        tristate_gate, busy, sig_valid, done;
    logic [15:0] sig;

    logic [4:0]  page_z, sig_page_z;
    logic [5:0]  stim_z;
    logic        tristate_gate_z, busy_z, sig_valid_z, done_z;
    logic [15:0] sig_z;

    logic [7:0]  lut [0:2047];

    assign cell_out = lut[{page, stim}];

    always #5 clk = ~clk;

    cell_sweep_sig #(.SETTLE(SETTLE), .SEED(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .page_first(page_first), .page_last(page_last), .tri_en(tri_en),
        .cell_out(cell_out), .page(page), .stim(stim),
        .tristate_gate(tristate_gate), .busy(busy), .sig(sig),
        .sig_page(sig_page), .sig_valid(sig_valid), .done(done)
    );

    cell_sweep_sig #(.SETTLE(SETTLE0), .SEED(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .page_first(page_first), .page_last(page_last), .tri_en(tri_en),
        .cell_out(8'h00), .page(page_z), .stim(stim_z),
        .tristate_gate(tristate_gate_z), .busy(busy_z), .sig(sig_z),
        .sig_page(sig_page_z), .sig_valid(sig_valid_z), .done(done_z)
    );

    typedef struct {
        logic [4:0]  pg;
        logic [15:0] sg;
        logic        dn;
    } rep_t;

    typedef struct {
        logic [4:0] pf;
        logic [4:0] pl;
        logic       tg;
        logic       disturb;
        int         npages;
    } vec_t;

    rep_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rep   = 0;
    int   n_done  = 0;
    logic exp_tri = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_sig(input logic [4:0] p, input logic [15:0] seed);
        logic [15:0] s;
        logic        carry;
        s = seed;
        for (int k = 0; k < 64; k++) begin
            carry = s[15];
            s = s << 1;
            if (carry) s = s ^ 16'h1021;
            s[7:0] = s[7:0] ^ lut[{p, 6'(k)}];
        end
        return s;
    endfunction

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Monitor: scoreboard pops on sig_valid, plus stimulus stability while busy.
    int         hold = 1;
    logic [5:0] prev_stim = 6'd0;
    logic [4:0] prev_page = 5'd0;
    logic       prev_busy = 1'b0;

    always @(posedge clk) begin
        #1;
        if (sig_valid) begin
            n_rep++;
            if (q.size() == 0) begin
                chk("unexpected_sig_valid", 32'd1, 32'd0);
            end else begin
                rep_t e;
                e = q.pop_front();
                chk("sig_page", 32'(sig_page), 32'(e.pg));
                chk("sig", 32'(sig), 32'(e.sg));
                chk("done_with_report", 32'(done), 32'(e.dn));
            end
        end else if (done) begin
            chk("done_without_sig_valid", 32'd1, 32'd0);
        end
        if (done) n_done++;
        if (busy) chk("tristate_gate", 32'(tristate_gate), 32'(exp_tri));
        if (busy && prev_busy && (stim != prev_stim || page != prev_page)) begin
            if (prev_stim != 6'd63) begin
                chk("stim_step", 32'(stim), 32'(6'(prev_stim + 6'd1)));
                chk("stim_hold", 32'(hold), 32'(SETTLE + 1));
                chk("page_stable", 32'(page), 32'(prev_page));
            end else begin
                chk("stim_wrap", 32'(stim), 32'd0);
                chk("page_step", 32'(page), 32'(5'(prev_page + 5'd1)));
                chk("report_hold", 32'(hold), 32'(SETTLE + 2));
            end
            hold = 1;
        end else if (busy && prev_busy) begin
            hold++;
        end else begin
            hold = 1;
        end
        prev_busy = busy;
        prev_stim = stim;
        prev_page = page;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [4];
        bit         ok;
        int         n0, nm, rep_s, done_s;
        logic [15:0] saved_sig;

        for (int i = 0; i < 2048; i++) lut[i] = 8'($urandom);
        tbl[0] = '{pf: 5'd30, pl: 5'd1,  tg: 1'b1, disturb: 1'b0, npages: 4};
        tbl[1] = '{pf: 5'd0,  pl: 5'd2,  tg: 1'b0, disturb: 1'b1, npages: 3};
        tbl[2] = '{pf: 5'd31, pl: 5'd0,  tg: 1'b1, disturb: 1'b1, npages: 2};
        tbl[3] = '{pf: 5'd12, pl: 5'd12, tg: 1'b1, disturb: 1'b0, npages: 1};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_page", 32'(page), 32'd0);
        chk("rst_stim", 32'(stim), 32'd0);
        chk("rst_tri", 32'(tristate_gate), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sig", 32'(sig), 32'd0);
        chk("rst_sig_page", 32'(sig_page), 32'd0);
        chk("rst_sig_valid", 32'(sig_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy_z", 32'(busy_z), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Single page 5..5: SEED=0 instance with zero data, plus latency of both instances
        q.push_back('{pg: 5'd5, sg: model_sig(5'd5, 16'hFFFF), dn: 1'b1});
        exp_tri = 1'b0;
        tri_en = 1'b0; page_first = 5'd5; page_last = 5'd5;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        chk("busy_rise_z", 32'(busy_z), 32'd1);
        n0 = 0; nm = 0;
        for (int n = 2; n < 400; n++) begin
            @(posedge clk); #1;
            if (sig_valid_z && n0 == 0) begin
                n0 = n;
                chk("zero_sig", 32'(sig_z), 32'h0);
                chk("zero_sig_page", 32'(sig_page_z), 32'd5);
                chk("zero_done", 32'(done_z), 32'd1);
            end
            if (sig_valid && nm == 0) nm = n;
            if (n0 != 0 && nm != 0) break;
        end
        chk("zero_latency", 32'(n0), 32'(64 * (SETTLE0 + 1) + 1));
        chk("sig_valid_latency", 32'(nm), 32'(64 * (SETTLE + 1) + 1));
        @(posedge clk); #1;
        chk("busy_fall", 32'(busy), 32'd0);
        chk("queue_empty_single", 32'(q.size()), 32'd0);

        // start+abort together in IDLE, then asynchronous reset during SETTLE
        exp_tri = 1'b1;
        tri_en = 1'b1; page_first = 5'd9; page_last = 5'd9;
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        chk("start_wins_abort", 32'(busy), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_tri", 32'(tristate_gate), 32'd0);
        chk("async_rst_page", 32'(page), 32'd0);
        chk("async_rst_stim", 32'(stim), 32'd0);
        chk("async_rst_sig", 32'(sig), 32'd0);
        chk("async_rst_sig_page", 32'(sig_page), 32'd0);
        chk("async_rst_sig_valid", 32'(sig_valid), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven sweeps
        for (int v = 0; v < 4; v++) begin
            rep_s = n_rep; done_s = n_done;
            for (int k = 0; k < tbl[v].npages; k++) begin
                logic [4:0] p;
                p = 5'(tbl[v].pf + 5'(k));
                q.push_back('{pg: p, sg: model_sig(p, 16'hFFFF), dn: (k == tbl[v].npages - 1)});
            end
            exp_tri = tbl[v].tg;
            tri_en = tbl[v].tg; page_first = tbl[v].pf; page_last = tbl[v].pl;
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            if (tbl[v].disturb) begin
                repeat (100) @(posedge clk);
                @(negedge clk) begin
                    start = 1'b1; page_first = 5'd7; page_last = 5'd7; tri_en = ~tbl[v].tg;
                end
                @(negedge clk) start = 1'b0;
            end
            wait_idle(300 * tbl[v].npages + 50, ok);
            chk("sweep_timeout", 32'(ok), 32'd1);
            chk("report_count", 32'(n_rep - rep_s), 32'(tbl[v].npages));
            chk("done_count", 32'(n_done - done_s), 32'd1);
            chk("queue_empty", 32'(q.size()), 32'd0);
            repeat (2) @(posedge clk);
        end

        // Abort on stimulus 40 of page 2
        saved_sig = sig;
        rep_s = n_rep; done_s = n_done;
        exp_tri = 1'b1;
        tri_en = 1'b1; page_first = 5'd2; page_last = 5'd3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (page == 5'd2 && stim == 6'd40) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort_reach_stim40", 32'(ok), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tri", 32'(tristate_gate), 32'd0);
        chk("abort_sig_hold", 32'(sig), 32'(saved_sig));
        chk("abort_no_sig_valid", 32'(sig_valid), 32'd0);
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_report", 32'(n_rep - rep_s), 32'd0);
        chk("abort_no_done", 32'(n_done - done_s), 32'd0);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        chk("abort_sig_final", 32'(sig), 32'(saved_sig));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
